// File: rtl/trng_pkg.sv
// trng_pkg: shared mode encodings, VN state type and default parameters for the TRNG conditioner
package trng_pkg;
  localparam logic [1:0] MODE_SINGLE    = 2'b00;
  localparam logic [1:0] MODE_XOR       = 2'b01;
  localparam logic [1:0] MODE_VN_XOR    = 2'b10;
  localparam logic [1:0] MODE_VN_SINGLE = 2'b11;
  typedef enum logic {VN_IDLE, VN_HAVE_FIRST} vn_state_t;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_OUT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_RCT_CUTOFF  = 32;
endpackage

// File: rtl/trng_sync.sv
// trng_sync: single-bit multi-flop synchroniser for an asynchronous oscillator input
module trng_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: samples NUM_CH synchronised entropy sources, combines/debiases them,
// packs bits into OUT_W-bit words and runs a repetition-count health test
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int RCT_CUTOFF  = DEF_RCT_CUTOFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] raw_i,
  input  logic [1:0]        mode,
  input  logic [2:0]        ch_sel,
  input  logic [DIV_W-1:0]  sample_div,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              health_fail
);
  localparam int CW = $clog2(OUT_W);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam logic [RW-1:0] CUT = RW'(RCT_CUTOFF);
  localparam logic [3:0] NCH = 4'(NUM_CH);
  logic [NUM_CH-1:0] s;
  logic [7:0] s_pad;
  logic [2:0] sel;
  logic [DIV_W-1:0] div_cnt;
  logic strobe, use_single, vn, c, cfg_chg, first, emit, ebit, done, same, last;
  logic [1:0] mode_q;
  logic [2:0] ch_sel_q;
  vn_state_t vn_state, vn_next;
  logic [OUT_W-1:0] sh, word;
  logic [CW-1:0] bcnt;
  logic [RW-1:0] rct_cnt;

  genvar i;
  for (i = 0; i < NUM_CH; i++) begin : g_sync
    trng_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(raw_i[i]), .q(s[i]));
  end

  assign s_pad      = 8'(s);
  assign sel        = ({1'b0, ch_sel} < NCH) ? ch_sel : 3'd0;
  assign use_single = (mode == MODE_SINGLE) || (mode == MODE_VN_SINGLE);
  assign vn         = (mode == MODE_VN_XOR) || (mode == MODE_VN_SINGLE);
  assign c          = use_single ? s_pad[sel] : ^s;
  assign strobe     = ena && (div_cnt == sample_div);
  assign cfg_chg    = (mode != mode_q) || (ch_sel != ch_sel_q);
  assign same       = (c == last);
  assign word       = {sh[OUT_W-2:0], ebit};
  assign done       = emit && (bcnt == CW'(OUT_W - 1));

  always_comb begin
    vn_next = (!ena || cfg_chg || !vn) ? VN_IDLE :
              !strobe ? vn_state :
              (vn_state == VN_IDLE) ? VN_HAVE_FIRST : VN_IDLE;
    emit = strobe && !health_fail && (vn ? (vn_state == VN_HAVE_FIRST && first != c) : 1'b1);
    ebit = vn ? first : c;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vn_state <= VN_IDLE;
      first    <= 1'b0;
      mode_q   <= '0;
      ch_sel_q <= '0;
      div_cnt  <= '0;
    end else begin
      vn_state <= vn_next;
      if (strobe && vn_state == VN_IDLE) first <= c;
      mode_q   <= mode;
      ch_sel_q <= ch_sel;
      div_cnt  <= (!ena || strobe) ? '0 : div_cnt + 1'b1;
    end

  // A completed word is only accepted if the output slot is free or being drained this cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh        <= '0;
      bcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emit) sh <= word;
      bcnt <= (!ena || done) ? '0 : bcnt + CW'(emit);
      if (!ena) out_valid <= 1'b0;
      else if (done && (!out_valid || out_ready)) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) out_valid <= 1'b0;
      if (done && out_valid && !out_ready) overrun <= 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rct_cnt     <= RW'(1);
      last        <= 1'b0;
      health_fail <= 1'b0;
    end else if (!ena) begin
      rct_cnt <= RW'(1);
      last    <= 1'b0;
    end else if (strobe) begin
      rct_cnt <= !same ? RW'(1) : (rct_cnt == CUT) ? rct_cnt : rct_cnt + 1'b1;
      last    <= c;
      if (same && rct_cnt >= CUT - 1'b1) health_fail <= 1'b1;
    end
endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed self-checking bench for trng_conditioner (default parameters)
module tb_trng_conditioner;
  import trng_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0, out_ready = 1'b0;
  logic [3:0] raw_i = '0;
  logic [1:0] mode = MODE_SINGLE;
  logic [2:0] ch_sel = '0;
  logic [7:0] sample_div = '0;
  logic [7:0] out_data;
  logic out_valid, overrun, health_fail;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  trng_conditioner dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_i(raw_i), .mode(mode), .ch_sel(ch_sel),
    .sample_div(sample_div), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .health_fail(health_fail)
  );

  // map 0: bit on ch1 (XOR constant), map 1: bit on XOR (ch1 constant), map 2: bit on ch0 (ch1 inverted)
  function automatic logic [3:0] raw_of(input int map, input logic b);
    return map == 0 ? (b ? 4'b0010 : 4'b1101) : map == 1 ? (b ? 4'b1011 : 4'b0110) : (b ? 4'b0001 : 4'b1110);
  endfunction

  task automatic do_reset(input logic [1:0] m, input logic [2:0] cs, input logic [7:0] sd, input logic rdy);
    rst_n = 1'b0; ena = 1'b0; mode = m; ch_sel = cs; sample_div = sd; out_ready = rdy; raw_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bit k of the stream is sampled at the posedge following the (k+2)-th driven negedge
  task automatic stream(input logic [31:0] bits, input int n, input int map);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      raw_i = raw_of(map, bits[n-1-i]);
      ena = (i >= 2);
    end
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #1;
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", out_data); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    tests++; if (health_fail !== 1'b0) begin fails++; $display("FAIL reset_health: got %b expected 0", health_fail); end
  endtask

  task automatic test_single;
    do_reset(MODE_SINGLE, 3'd1, 8'd0, 1'b1);
    stream(32'hB2, 8, 0);
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b expected 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'hB2) begin fails++; $display("FAIL single_data: got %h expected b2", out_data); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_handshake: got %b expected 0", out_valid); end
  endtask

  task automatic test_xor;
    do_reset(MODE_XOR, 3'd1, 8'd0, 1'b1);
    stream(32'h6C, 8, 1);
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL xor_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'h6C) begin fails++; $display("FAIL xor_data: got %h expected 6c", out_data); end
  endtask

  task automatic test_ch_sel;
    do_reset(MODE_SINGLE, 3'd6, 8'd0, 1'b1);
    stream(32'h93, 8, 2);
    repeat (3) @(negedge clk);
    tests++; if (out_data !== 8'h93) begin fails++; $display("FAIL chsel_default: got %h expected 93", out_data); end
  endtask

  task automatic test_vn;
    do_reset(MODE_VN_XOR, 3'd0, 8'd0, 1'b0);
    stream({2'b00, {3{10'b1101100001}}}, 30, 1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL vn_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'h49) begin fails++; $display("FAIL vn_data: got %h expected 49", out_data); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL vn_overrun: got %b expected 0", overrun); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL vn_handshake: got %b expected 0", out_valid); end
  endtask

  task automatic test_overrun;
    do_reset(MODE_SINGLE, 3'd1, 8'd0, 1'b0);
    stream(32'hA53C, 16, 0);
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_early: got %b expected 0", overrun); end
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL ovr_data: got %h expected a5", out_data); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain: got %b expected 0", out_valid); end
    tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL ovr_hold: got %h expected a5", out_data); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_health;
    int seen = 0;
    do_reset(MODE_SINGLE, 3'd1, 8'd3, 1'b1);
    raw_i = 4'b0010;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    repeat (127) @(negedge clk);
    tests++; if (health_fail !== 1'b0) begin fails++; $display("FAIL rct_early: got %b expected 0", health_fail); end
    @(negedge clk);
    tests++; if (health_fail !== 1'b1) begin fails++; $display("FAIL rct_trip: got %b expected 1", health_fail); end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rct_block: got %0d valid cycles expected 0", seen); end
    tests++; if (health_fail !== 1'b1) begin fails++; $display("FAIL rct_persist: got %b expected 1", health_fail); end
    rst_n = 1'b0;
    #1;
    tests++; if (health_fail !== 1'b0) begin fails++; $display("FAIL rct_clear: got %b expected 0", health_fail); end
  endtask

  task automatic test_async_reset;
    do_reset(MODE_SINGLE, 3'd1, 8'd0, 1'b0);
    stream(32'h14B6, 13, 0);
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arst_pre: got %b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    raw_i = 4'b0010;
    #1;
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL arst_data: got %h expected 00", out_data); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_partial: got %b expected 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arst_word: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'h3F) begin fails++; $display("FAIL arst_data2: got %h expected 3f", out_data); end
  endtask

  task automatic test_ena;
    do_reset(MODE_SINGLE, 3'd1, 8'd4, 1'b0);
    raw_i = 4'b0010;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    repeat (56) @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ena_pre: got %b expected 1", out_valid); end
    ena = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ena_clear: got %b expected 0", out_valid); end
    repeat (9) @(negedge clk);
    ena = 1'b1;
    repeat (39) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ena_partial: got %b expected 0", out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ena_word: got %b expected 1", out_valid); end
    tests++; if (out_data !== 8'hFF) begin fails++; $display("FAIL ena_data: got %h expected ff", out_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_xor;
    test_ch_sel;
    test_vn;
    test_overrun;
    test_health;
    test_async_reset;
    test_ena;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trng_conditioner.md
Name: trng_conditioner

Overview:
Parametrised successor to the single-channel biased-oscillator sampler. It takes NUM_CH asynchronous entropy sources (biased ring-oscillator outputs) and synchronises each one. It samples them on a programmable strobe and combines them by a selected mode, with optional Von Neumann debiasing. It packs the resulting bits into OUT_W-bit words on a valid/ready interface, and it runs a continuous repetition-count health test. It sits between the oscillator/bias array and the top-level output pins.

Parameters:
NUM_CH, 4, number of raw entropy inputs (1..8)
OUT_W, 8, output word width in bits (2..32)
SYNC_STAGES, 2, flops per input synchroniser (>=2)
DIV_W, 8, width of sample-divider value
RCT_CUTOFF, 32, consecutive identical samples that trip the health test (2..2^16-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  block enable; low = hold idle
raw_i  in  NUM_CH  asynchronous oscillator bits
mode  in  2  00 = single channel, 01 = XOR of all channels, 10 = Von Neumann on XOR, 11 = Von Neumann on single channel
ch_sel  in  3  channel index for modes 00/11; values >= NUM_CH select channel 0
sample_div  in  DIV_W  strobe period = sample_div+1 clocks
out_data  out  OUT_W  packed random word; first sampled bit is in the MSB
out_valid  out  1  word available
out_ready  in  1  consumer accepts word
overrun  out  1  sticky: a bit was dropped because the word was held
health_fail  out  1  sticky: repetition-count test tripped

Behaviour:
- Reset (rst_n low, async): all synchroniser flops 0. Prescaler 0. VN state IDLE. Bit count 0. out_data 0. out_valid 0. overrun 0. health_fail 0. RCT counter 1, last bit 0.
- Synchroniser: each raw_i bit passes through SYNC_STAGES flops; s[i] is the last stage.
- Prescaler: counts 0..sample_div. The strobe asserts for one cycle when count == sample_div, and the count then returns to 0. With sample_div = 0 the strobe fires every cycle. A change to sample_div takes effect at the next wrap; if count > new value, the count wraps at its DIV_W-bit maximum.
- Combined bit c: s[ch_sel] in modes 00/11; XOR of all s in modes 01/10. Sampled only on the strobe.
- VN state machine (modes 10/11), states IDLE and HAVE_FIRST:
  - IDLE + strobe: store c as first, go to HAVE_FIRST.
  - HAVE_FIRST + strobe: if first != c, emit bit = first; if equal, emit nothing. Either way, go to IDLE.
  - In modes 00/01 every strobe emits c directly and the state stays IDLE.
- Packer:
  - An emitted bit shifts into the shift register at the LSB; the bit count increments.
  - When the count reaches OUT_W, the register loads into out_data and out_valid sets on the next edge; the count returns to 0.
  - out_valid stays high until the cycle where out_valid and out_ready are both high; it clears on the following edge.
  - If a word completes while out_valid is still high, that word is discarded and overrun sets.
  - If the handshake and a new word completion fall in the same cycle, the new word loads and out_valid stays 1.
  - overrun clears only on reset.
- Health test (RCT), on raw c at every strobe regardless of VN:
  - If c == last bit, the counter increments and saturates at RCT_CUTOFF; otherwise the counter is 1 and last bit = c.
  - When the counter reaches RCT_CUTOFF, health_fail sets and stays set until reset.
  - While health_fail is set, no bits are emitted and out_valid cannot newly assert; a word already valid remains available until handshaken.
- ena low (synchronous): prescaler, VN state, bit count and RCT counter return to reset values; out_valid clears; out_data, overrun and health_fail hold. Synchronisers keep running.
- Changing mode or ch_sel: the VN state returns to IDLE on the next edge; partial shift contents are kept.
- Latency: a raw edge reaches the strobe sample after SYNC_STAGES..SYNC_STAGES+sample_div+1 clocks. In modes 00/01 out_valid rises one clock after the OUT_W-th strobe.

Decomposition:
- Package trng_pkg holds:
  - the mode encodings MODE_SINGLE, MODE_XOR, MODE_VN_XOR, MODE_VN_SINGLE;
  - the VN state enum VN_IDLE, VN_HAVE_FIRST;
  - the default-parameter constants.
- Sub-module trng_sync: a parametrised SYNC_STAGES-deep single-bit synchroniser with async active-low reset, instantiated NUM_CH times.
- Prescaler, VN state machine, packer and RCT stay in the top module.

Test Plan:
1. mode 00, ch_sel = 1, sample_div = 0; drive raw_i[1] with pattern 1,0,1,1,0,0,1,0 aligned to the strobe -> after SYNC_STAGES + 8 clocks, out_valid = 1 and out_data = 8'hB2; with out_ready = 1 it clears the next clock.
2. mode 10, NUM_CH = 4, XOR stream 1,1,0,1,1,0,0,0,0,1, repeated until 8 bits are emitted -> pairs (1,1) drop, (0,1) emits 0, (1,0) emits 1, (0,0) drops, (0,1) emits 0; the first emitted bits are 0,1,0 and the word is checked bit-exact against the model.
3. Hold out_ready = 0 while two words complete -> first word stable in out_data, overrun = 1; raising out_ready gives a handshake on the first word only.
4. Hold the combined bit constant at 1 with RCT_CUTOFF = 32, sample_div = 3 -> health_fail = 1 after the 32nd identical strobe (about 128 clocks); no further out_valid; persists until rst_n pulses.
5. Assert rst_n low asynchronously mid-word (bit count 5, out_valid = 1) -> all outputs 0 immediately, without waiting for a clock edge; after release, the next word needs a full 8 new bits.
6. sample_div = 4, ena dropped for 10 clocks mid-word -> out_valid = 0 and partial bits discarded; after ena returns, the first strobe occurs 5 clocks later.
